// File: rtl/serial_chunk_adder.sv
// serial_chunk_adder: WIDTH-bit add/subtract computed CHUNK bits per clock with a registered carry.
// Optional signed-overflow output is enabled by defining ADDER_OVF_EN.
`default_nettype none

module serial_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NCHUNK - 1);

  generate
    if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_chunk
      $error("serial_chunk_adder: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic [CHUNK:0]   w_chunk_sum;
  logic [WIDTH-1:0] w_acc_next;

  assign w_last      = (r_cnt == C_LAST);
  assign w_chunk_sum = {1'b0, r_opa[CHUNK-1:0]} + {1'b0, r_opb[CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, r_carry};

  // Each new chunk enters at the MSB end, so after NCHUNK steps the
  // accumulator holds the full result in order.
  generate
    if (CHUNK == WIDTH) begin : g_single
      assign w_acc_next = w_chunk_sum[CHUNK-1:0];
    end else begin : g_multi
      logic [WIDTH-CHUNK-1:0] r_acc;
      assign w_acc_next = {w_chunk_sum[CHUNK-1:0], r_acc};
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_acc <= '0;
        end else if (r_state == S_CALC) begin
          r_acc <= w_acc_next[WIDTH-1:CHUNK];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    w_accept  = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = ~rst;
        w_accept = in_valid & ~rst;
        if (w_accept) begin
          w_next = S_CALC;
        end
      end
      S_CALC: begin
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_opa   <= a;
      r_opb   <= sub ? ~b : b;
      r_carry <= sub ? 1'b1 : cin;
      r_cnt   <= '0;
    end else if (r_state == S_CALC) begin
      r_opa   <= r_opa >> CHUNK;
      r_opb   <= r_opb >> CHUNK;
      r_carry <= w_chunk_sum[CHUNK];
      r_cnt   <= r_cnt + 1'b1;
      // Result registers load only on the final chunk, so no partial sum is visible.
      if (w_last) begin
        r_sum  <= w_acc_next;
        r_cout <= w_chunk_sum[CHUNK];
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

`ifdef ADDER_OVF_EN
  logic r_ovf;
  logic w_msb_cin;

  // Carry into the MSB recovered from the MSB sum bit and its two operand bits.
  assign w_msb_cin = r_opa[CHUNK-1] ^ r_opb[CHUNK-1] ^ w_chunk_sum[CHUNK-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if ((r_state == S_CALC) && w_last) begin
      r_ovf <= w_msb_cin ^ w_chunk_sum[CHUNK];
    end else if ((r_state == S_DONE) && out_ready) begin
      r_ovf <= 1'b0;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_chunk_adder.sv
// Directed self-checking bench for serial_chunk_adder: a CHUNK=4 instance and a CHUNK=16 instance.
`default_nettype none

module tb_serial_chunk_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  in_valid_v;
  logic [1:0]  in_ready_v;
  logic [1:0]  out_valid_v;
  logic [1:0]  out_ready_v;
  logic [15:0] a, b;
  logic        cin, sub;
  logic [15:0] sum0, sum1;
  logic [1:0]  cout_v;
  logic [1:0]  ovf_v;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  serial_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_v[0]),
    .out_ready(out_ready_v[0]), .sum(sum0), .cout(cout_v[0])
`ifdef ADDER_OVF_EN
    , .ovf(ovf_v[0])
`endif
  );

  serial_chunk_adder #(.WIDTH(16), .CHUNK(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_v[1]),
    .out_ready(out_ready_v[1]), .sum(sum1), .cout(cout_v[1])
`ifdef ADDER_OVF_EN
    , .ovf(ovf_v[1])
`endif
  );

`ifndef ADDER_OVF_EN
  assign ovf_v = 2'b00;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] sum_of(input int sel);
    return (sel == 0) ? sum0 : sum1;
  endfunction

  // One operation on DUT sel (latency n chunks); out_ready held low for hold cycles in DONE.
  task automatic run_op(input int sel, input int n, input logic [15:0] ta, input logic [15:0] tb,
                        input logic tcin, input logic tsub, input logic [15:0] esum,
                        input logic ecout, input logic eovf, input int hold);
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready_v[sel]), 32'd1);
    a = ta; b = tb; cin = tcin; sub = tsub;
    in_valid_v[sel]  = 1'b1;
    out_ready_v[sel] = (hold == 0);
    @(posedge clk);
    #1;
    in_valid_v[sel] = 1'b0;
    a = ~ta; b = ~tb; cin = ~tcin; sub = ~tsub;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check("calc_out_valid", 32'(out_valid_v[sel]), 32'd0);
      check("calc_in_ready", 32'(in_ready_v[sel]), 32'd0);
    end
    @(negedge clk);
    check("done_out_valid", 32'(out_valid_v[sel]), 32'd1);
    check("done_sum", 32'(sum_of(sel)), 32'(esum));
    check("done_cout", 32'(cout_v[sel]), 32'(ecout));
`ifdef ADDER_OVF_EN
    check("done_ovf", 32'(ovf_v[sel]), 32'(eovf));
`endif
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_out_valid", 32'(out_valid_v[sel]), 32'd1);
      check("hold_in_ready", 32'(in_ready_v[sel]), 32'd0);
      check("hold_sum", 32'(sum_of(sel)), 32'(esum));
      check("hold_cout", 32'(cout_v[sel]), 32'(ecout));
    end
    out_ready_v[sel] = 1'b1;
    @(negedge clk);
    check("after_out_valid", 32'(out_valid_v[sel]), 32'd0);
    check("after_in_ready", 32'(in_ready_v[sel]), 32'd1);
`ifdef ADDER_OVF_EN
    check("after_ovf_clear", 32'(ovf_v[sel]), 32'd0);
`endif
  endtask

  initial begin
    rst = 1'b1; in_valid_v = 2'b00; out_ready_v = 2'b11;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready_v), 32'd0);
    check("rst_out_valid", 32'(out_valid_v), 32'd0);
    check("rst_sum0", 32'(sum0), 32'd0);
    check("rst_cout", 32'(cout_v), 32'd0);
    check("rst_ovf", 32'(ovf_v), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready_v), 32'd3);

    for (int s = 0; s < 2; s++) begin
      int n;
      n = (s == 0) ? 4 : 1;
      run_op(s, n, 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 0);
      run_op(s, n, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
      run_op(s, n, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
      run_op(s, n, 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0);
      run_op(s, n, 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 0);
      run_op(s, n, 16'hA5A5, 16'h5A5A, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 3);
      run_op(s, n, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
      run_op(s, n, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1);
      run_op(s, n, 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 0);
    end

    // Reset two cycles into CALC discards the operation and clears the held result.
    @(negedge clk);
    a = 16'h00F0; b = 16'h000F; cin = 1'b0; sub = 1'b0;
    in_valid_v[0] = 1'b1;
    @(posedge clk);
    #1 in_valid_v[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid_v[0]), 32'd0);
    check("midrst_sum", 32'(sum0), 32'd0);
    check("midrst_cout", 32'(cout_v[0]), 32'd0);
    check("midrst_in_ready", 32'(in_ready_v[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("midrst_no_result", 32'(out_valid_v[0]), 32'd0);
    end
    run_op(0, 4, 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
